// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES-128 round sequencer
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        GAP,
        DONE
    } aes_state_e;

    localparam int AES_NUM_ROUNDS = 10;
    localparam int AES_BLK_W      = 128;
    localparam int AES_RC_W       = 4;

    localparam logic [AES_RC_W-1:0] AES_LAST_RC = AES_RC_W'(AES_NUM_ROUNDS);

endpackage

// File: rtl/aes_round_seq.sv
// rtl/aes_round_seq.sv - iterative AES-128 sequencer driving an external round datapath
module aes_round_seq
    import aes_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AES_BLK_W-1:0]  in_data,
    input  logic [AES_BLK_W-1:0]  in_key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AES_BLK_W-1:0]  out_data,
    output logic                  err,
    output logic                  rnd_start,
    output logic [AES_RC_W-1:0]   rnd_rc,
    output logic                  rnd_last,
    output logic [AES_BLK_W-1:0]  rnd_data,
    output logic [AES_BLK_W-1:0]  rnd_key,
    input  logic                  rnd_done,
    input  logic [AES_BLK_W-1:0]  rnd_out,
    input  logic [AES_BLK_W-1:0]  rnd_keyout
);

    localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    aes_state_e           state;
    logic [AES_BLK_W-1:0] st_q;
    logic [AES_BLK_W-1:0] key_q;
    logic [AES_RC_W-1:0]  cnt;
    logic [TMO_W-1:0]     tmo;
    logic                 run;

    // All handshake and datapath outputs decode straight from the state register,
    // so the round inputs stay frozen for the whole RUN dwell.
    assign run       = (state == RUN);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = out_valid ? st_q : '0;
    assign rnd_start = run;
    assign rnd_rc    = run ? cnt : '0;
    assign rnd_last  = run && (cnt == AES_LAST_RC);
    assign rnd_data  = run ? st_q : '0;
    assign rnd_key   = run ? key_q : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            st_q  <= '0;
            key_q <= '0;
            cnt   <= '0;
            tmo   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st_q  <= in_data ^ in_key;
                        key_q <= in_key;
                        cnt   <= AES_RC_W'(1);
                        tmo   <= '0;
                        err   <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // A completion on the final timeout cycle still counts as success.
                    if (rnd_done) begin
                        st_q  <= rnd_out;
                        key_q <= rnd_keyout;
                        tmo   <= '0;
                        if (cnt == AES_LAST_RC) begin
                            state <= DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= GAP;
                        end
                    end else if (tmo == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                GAP: begin
                    state <= RUN;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_seq.sv
// tb/tb_aes_round_seq.sv - self-checking bench for aes_round_seq with a behavioural AES model
module tb_aes_round_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         err;
    logic         rnd_start;
    logic [3:0]   rnd_rc;
    logic         rnd_last;
    logic [127:0] rnd_data;
    logic [127:0] rnd_key;
    logic         rnd_done;
    logic [127:0] rnd_out;
    logic [127:0] rnd_keyout;

    always #5 clk = ~clk;

    aes_round_seq #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_key     (in_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .err        (err),
        .rnd_start  (rnd_start),
        .rnd_rc     (rnd_rc),
        .rnd_last   (rnd_last),
        .rnd_data   (rnd_data),
        .rnd_key    (rnd_key),
        .rnd_done   (rnd_done),
        .rnd_out    (rnd_out),
        .rnd_keyout (rnd_keyout)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // AES primitives; bytes are numbered from the MSB, column-major.
    logic [7:0] sbox_t [256];
    logic       sbox_ready = 1'b0;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = sbox_t[s[127-8*(r+4*((c+r)%4)) -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s);
        logic [127:0] o = '0;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(r+4*c) -: 8];
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rcon = 8'h01;
        logic [127:0] s;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ key;
        for (int r = 1; r <= 10; r++) begin
            s = sub_shift(s);
            if (r != 10) s = mix(s);
            s ^= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    function automatic logic [255:0] round_model(input logic [127:0] d, input logic [127:0] k,
                                                 input logic [3:0] rc, input logic last);
        logic [7:0]   rcon = 8'h01;
        logic [31:0]  t;
        logic [127:0] nk;
        logic [127:0] nd;
        for (int i = 1; i < int'(rc); i++) rcon = xt(rcon);
        t = subword({k[23:0], k[31:24]}) ^ {rcon, 24'h0};
        nk[127:96] = k[127:96] ^ t;
        nk[95:64]  = k[95:64]  ^ nk[127:96];
        nk[63:32]  = k[63:32]  ^ nk[95:64];
        nk[31:0]   = k[31:0]   ^ nk[63:32];
        nd = sub_shift(d);
        if (!last) nd = mix(nd);
        return {nd ^ nk, nk};
    endfunction

    // Round datapath stand-in with programmable completion delay.
    int   rnd_delay = 0;
    logic done_en   = 1'b1;
    int   wait_cnt  = 0;

    assign rnd_done = rnd_start && done_en && (wait_cnt >= rnd_delay);

    always @(posedge clk) begin
        if (!rnd_start || rnd_done) wait_cnt <= 0;
        else                        wait_cnt <= wait_cnt + 1;
    end

    always @(rnd_data or rnd_key or rnd_rc or rnd_last or sbox_ready)
        {rnd_out, rnd_keyout} = round_model(rnd_data, rnd_key, rnd_rc, rnd_last);

    logic rand_rdy = 1'b0;
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    typedef struct {
        logic [127:0] ct;
        int           t_acc;
        int           dly;
    } exp_t;

    exp_t exp_q [$];
    int   cyc = 0;
    int   run_rc = 0;
    int   rounds_seen = 0;
    int   lasts_seen = 0;
    int   accepts = 0;
    logic p_start = 1'b0, p_done = 1'b0, p_ov = 1'b0, p_or = 1'b0;
    logic [127:0] p_data = '0, p_key = '0, p_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            run_rc = 0;
            exp_q.delete();
            p_start = 1'b0;
            p_ov    = 1'b0;
        end else begin
            chk1("ready_valid_exclusive", in_ready && out_valid, 1'b0);
            if (!rnd_start) begin
                chk1("rnd_idle_zero", (rnd_rc != 4'd0) || rnd_last || (rnd_data != '0) || (rnd_key != '0), 1'b0);
            end else begin
                chk_int("rnd_rc", int'(rnd_rc), run_rc);
                chk1("rnd_last", rnd_last, run_rc == 10);
                if (p_start && !p_done) begin
                    chk("rnd_data_stable", rnd_data, p_data);
                    chk("rnd_key_stable", rnd_key, p_key);
                end
            end
            if (out_valid) begin
                chk1("out_valid_has_block", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    chk("out_data", out_data, exp_q[0].ct);
                    if (!p_ov) chk_int("latency", cyc - exp_q[0].t_acc, 10 * exp_q[0].dly + 20);
                end
            end
            if (p_ov && !p_or) begin
                chk1("out_valid_held", out_valid, 1'b1);
                chk("out_data_held", out_data, p_out);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{aes_encrypt(in_data, in_key), cyc, rnd_delay});
                run_rc      = 1;
                rounds_seen = 0;
                lasts_seen  = 0;
                accepts++;
            end
            if (rnd_start && rnd_done) begin
                rounds_seen++;
                if (rnd_last) lasts_seen++;
                run_rc++;
            end
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            p_start = rnd_start;
            p_done  = rnd_done;
            p_data  = rnd_data;
            p_key   = rnd_key;
            p_ov    = out_valid;
            p_or    = out_ready;
            p_out   = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        chk1("wait_idle_bound", in_ready, 1'b1);
    endtask

    task automatic wait_ov(output int n);
        n = 0;
        while (!out_valid && n < 400) begin
            tick();
            n++;
        end
        chk1("wait_out_valid_bound", out_valid, 1'b1);
    endtask

    task automatic send(input logic [127:0] pt, input logic [127:0] key);
        wait_idle();
        in_valid = 1'b1;
        in_data  = pt;
        in_key   = key;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [127:0] key1 = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] pt1  = 128'h00112233445566778899aabbccddeeff;
    logic [127:0] ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    logic [127:0] key2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] pt2  = 128'h3243f6a8885a308d313198a2e0370734;
    logic [127:0] ct2  = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]   inv;
        logic [127:0] xa;
        logic [127:0] xk;
        int           n;
        int           a0;

        for (int v = 0; v < 256; v++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(v));
            sbox_t[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        sbox_ready = 1'b1;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        chk1("reset_in_ready", in_ready, 1'b1);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_rnd_start", rnd_start, 1'b0);
        chk1("reset_err", err, 1'b0);
        chk("reset_out_data", out_data, 128'h0);
        rst_n = 1'b1;
        tick();

        // FIPS-197 C.1 with an immediate datapath
        send(pt1, key1);
        wait_ov(n);
        chk_int("c1_latency", n + 1, 20);
        chk("c1_ciphertext", out_data, ct1);
        wait_idle();
        chk_int("c1_rounds", rounds_seen, 10);
        chk_int("c1_last_rounds", lasts_seen, 1);

        // FIPS-197 B with a 3-cycle datapath
        rnd_delay = 3;
        send(pt2, key2);
        wait_ov(n);
        chk_int("b_latency", n + 1, 50);
        chk("b_ciphertext", out_data, ct2);
        wait_idle();
        rnd_delay = 0;

        // back-pressure, then a back-to-back block
        out_ready = 1'b0;
        send(pt1, key1);
        wait_ov(n);
        for (int i = 0; i < 7; i++) begin
            chk("bp_out_data", out_data, ct1);
            chk1("bp_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = pt2;
        in_key    = key2;
        tick();
        chk1("b2b_ready_after_handshake", in_ready, 1'b1);
        chk1("b2b_out_valid_dropped", out_valid, 1'b0);
        tick();
        chk1("b2b_accepted", in_ready, 1'b0);
        in_valid = 1'b0;
        wait_ov(n);
        chk("b2b_ciphertext", out_data, ct2);
        wait_idle();

        // datapath never completes
        done_en = 1'b0;
        send(rand128(), rand128());
        for (int i = 0; i < 15; i++) begin
            chk1("tmo_no_out_valid", out_valid, 1'b0);
            tick();
        end
        chk1("tmo_still_run", in_ready, 1'b0);
        chk1("tmo_err_not_yet", err, 1'b0);
        tick();
        chk1("tmo_idle", in_ready, 1'b1);
        chk1("tmo_err_set", err, 1'b1);
        exp_q.delete();
        done_en = 1'b1;
        tick();
        chk1("tmo_err_sticky", err, 1'b1);
        chk1("tmo_out_valid_low", out_valid, 1'b0);
        send(rand128(), rand128());
        chk1("tmo_err_cleared", err, 1'b0);
        wait_ov(n);
        wait_idle();

        // reset during round 5
        send(pt1, key1);
        n = 0;
        while (!(rnd_start && run_rc == 5) && n < 400) begin
            tick();
            n++;
        end
        chk_int("rst_reached_round5", run_rc, 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_rnd_start", rnd_start, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        send(pt1, key1);
        wait_ov(n);
        chk("rst_rerun_ciphertext", out_data, ct1);
        wait_idle();

        // in_valid held through RUN with a different block
        xa = rand128();
        xk = rand128();
        a0 = accepts;
        wait_idle();
        in_valid = 1'b1;
        in_data  = xa;
        in_key   = xk;
        tick();
        in_data  = rand128();
        in_key   = rand128();
        n = 0;
        while (!out_valid && n < 400) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("held_valid_ciphertext", out_data, aes_encrypt(xa, xk));
        wait_idle();
        chk_int("held_valid_accepts", accepts - a0, 1);

        // randomized blocks, delays and consumer stalls
        rand_rdy = 1'b1;
        for (int b = 0; b < 20; b++) begin
            wait_idle();
            rnd_delay = $urandom_range(0, 3);
            send(rand128(), rand128());
            wait_ov(n);
            wait_idle();
        end
        rand_rdy = 1'b0;
        tick();
        out_ready = 1'b1;
        repeat (3) tick();
        chk_int("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
